// File: rtl/sub_serial_alu_if.sv
// Start/done handshake bundle for the serial subtractor.
// Optional flag outputs appear only when SUB_SERIAL_FLAGS_EN is defined.
interface sub_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Bout;
`ifdef SUB_SERIAL_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;
`endif

  modport master (
    output start, A, B,
    input  busy, done, result, Bout
`ifdef SUB_SERIAL_FLAGS_EN
    , input zero, negative, overflow
`endif
  );

  modport slave (
    input  start, A, B,
    output busy, done, result, Bout
`ifdef SUB_SERIAL_FLAGS_EN
    , output zero, negative, overflow
`endif
  );
endinterface

// File: rtl/sub_serial_alu.sv
// Multi-cycle subtractor: result = A + ~B + 1, CHUNK bits per cycle LSB first.
// Optional zero/negative/overflow flags are enabled by macro SUB_SERIAL_FLAGS_EN.
module sub_serial_alu #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sub_serial_alu_if.slave     bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("sub_serial_alu: CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] nb_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             bout_r;
  logic             busy_r;
  logic             done_r;
  logic [CHUNK-1:0] sum_s;
  logic             cout_s;

  // Next-state decode; a start is honoured from IDLE and from DONE.
  always_comb begin
    state_nx = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          accept_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(N - 1)) begin
          state_nx = DONE;
          last_s   = 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nx = RUN;
          accept_s = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // One CHUNK-bit adder slice fed from the low end of the operand shifters.
  always_comb begin
    {cout_s, sum_s} = {1'b0, a_r[CHUNK-1:0]} + {1'b0, nb_r[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_r};
  end

  // State register with busy/done registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx == RUN);
      done_r  <= (state_nx == DONE);
    end
  end

  // Operand shifters, carry chain, chunk counter and result/borrow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      nb_r     <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      result_r <= '0;
      bout_r   <= 1'b0;
    end else if (accept_s) begin
      a_r     <= bus.A;
      nb_r    <= ~bus.B;
      carry_r <= 1'b1;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_r     <= a_r >> CHUNK;
      nb_r    <= nb_r >> CHUNK;
      carry_r <= cout_s;
      cnt_r   <= cnt_r + CW'(1);
      for (int k = 0; k < N; k++) begin
        if (cnt_r == CW'(k)) begin
          result_r[k*CHUNK +: CHUNK] <= sum_s;
        end
      end
      if (last_s) begin
        bout_r <= ~cout_s;
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.Bout   = bout_r;

`ifdef SUB_SERIAL_FLAGS_EN
  logic zacc_r;
  logic a_msb_r;
  logic b_msb_r;
  logic zero_r;
  logic neg_r;
  logic ovf_r;

  // Flags: zero accumulates per slice; the last slice supplies the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_r  <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      zacc_r  <= 1'b1;
      a_msb_r <= bus.A[WIDTH-1];
      b_msb_r <= bus.B[WIDTH-1];
    end else if (state_r == RUN) begin
      zacc_r <= zacc_r & (sum_s == '0);
      if (last_s) begin
        zero_r <= zacc_r & (sum_s == '0);
        neg_r  <= sum_s[CHUNK-1];
        ovf_r  <= (a_msb_r != b_msb_r) && (sum_s[CHUNK-1] != a_msb_r);
      end
    end
  end

  assign bus.zero     = zero_r;
  assign bus.negative = neg_r;
  assign bus.overflow = ovf_r;
`endif
endmodule

// File: tb/tb_sub_serial_alu.sv
// Self-checking bench for sub_serial_alu: directed and random subtractions
// against a plain-arithmetic model, plus handshake and mid-operation reset.
module tb_sub_serial_alu;
  localparam int WIDTH = 32;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  sub_serial_alu_if #(.WIDTH(WIDTH)) bus ();

  sub_serial_alu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic bo,
                                  output logic z, output logic n, output logic v);
    r  = a - b;
    bo = (a < b);
    z  = (r == 32'd0);
    n  = r[31];
    v  = (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse, scrambles operands, waits (bounded) for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt,
                       output logic [31:0] res, output logic bo,
                       output logic [2:0] flg);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    lat = -1; busy_cnt = 0; res = 32'd0; bo = 1'b0; flg = 3'd0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = c; res = bus.result; bo = bus.Bout;
`ifdef SUB_SERIAL_FLAGS_EN
        flg = {bus.zero, bus.negative, bus.overflow};
`endif
      end else begin
        tick();
      end
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat, bc;
    logic [31:0] res, er;
    logic bo, ebo, ez, en, ev;
    logic [2:0] flg;
    ref_sub(a, b, er, ebo, ez, en, ev);
    do_op(a, b, lat, bc, res, bo, flg);
    total_cnt++;
    if (lat !== N) $display("FAIL %s_latency: got %0d expected %0d", name, lat, N); else pass_cnt++;
    total_cnt++;
    if (res !== er) $display("FAIL %s_result: got %h expected %h", name, res, er); else pass_cnt++;
    total_cnt++;
    if (bo !== ebo) $display("FAIL %s_bout: got %b expected %b", name, bo, ebo); else pass_cnt++;
`ifdef SUB_SERIAL_FLAGS_EN
    total_cnt++;
    if (flg !== {ez, en, ev}) $display("FAIL %s_flags: got %b expected %b", name, flg, {ez, en, ev});
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    tick(); tick();
    total_cnt++;
    if ({bus.busy, bus.done, bus.Bout} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {bus.busy, bus.done, bus.Bout});
    else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'd0) $display("FAIL reset_result: got %h expected 0", bus.result); else pass_cnt++;
`ifdef SUB_SERIAL_FLAGS_EN
    total_cnt++;
    if ({bus.zero, bus.negative, bus.overflow} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {bus.zero, bus.negative, bus.overflow});
    else pass_cnt++;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [31:0] res;
    logic bo;
    logic [2:0] flg;
    do_op(32'd10, 32'd3, lat, bc, res, bo, flg);
    total_cnt++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++;
    if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", bc); else pass_cnt++;
    total_cnt++;
    if (res !== 32'h0000_0007) $display("FAIL basic_result: got %h expected 00000007", res); else pass_cnt++;
    total_cnt++;
    if (bo !== 1'b0) $display("FAIL basic_bout: got %b expected 0", bo); else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'h0000_0007) $display("FAIL basic_result_hold: got %h expected 00000007", bus.result);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    logic [31:0] ta [4] = '{32'd3, 32'h5A5A_5A5A, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] tb_ [4] = '{32'd10, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      check_op($sformatf("edge%0d", i), ta[i], tb_[i]);
      tick(); tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 6 == 0) ? a : $urandom;
      if (i % 5 == 1) b = a + 32'd1;
      check_op($sformatf("rand%0d", i), a, b);
      if (i % 2 == 0) tick();
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.A = 32'd100; bus.B = 32'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.A = 32'd5; bus.B = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int c = 3; c < 40 && lat < 0; c++) begin
      if (bus.done) lat = c; else tick();
    end
    total_cnt++;
    if (lat !== N) $display("FAIL ignore_latency: got %0d expected %0d", lat, N); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'd99) $display("FAIL ignore_result: got %0d expected 99", bus.result); else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    bus.A = 32'd7; bus.B = 32'd2; bus.start = 1'b1;
    tick();
    c1 = -1; c2 = -1;
    for (int c = 0; c < 40 && c2 < 0; c++) begin
      if (c1 >= 0 && c == c1 + 1) bus.start = 1'b0;
      if (bus.done) begin
        if (c1 < 0) c1 = c; else c2 = c;
      end
      if (c2 < 0) tick();
    end
    bus.start = 1'b0;
    total_cnt++;
    if (c1 !== N) $display("FAIL b2b_first_done: got %0d expected %0d", c1, N); else pass_cnt++;
    total_cnt++;
    if (c2 - c1 !== N + 1) $display("FAIL b2b_spacing: got %0d expected %0d", c2 - c1, N + 1); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'd5) $display("FAIL b2b_result: got %0d expected 5", bus.result); else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.A = 32'd50; bus.B = 32'd20; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.Bout} !== 3'b000)
      $display("FAIL midrst_ctrl: got %b expected 000", {bus.busy, bus.done, bus.Bout});
    else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'd0) $display("FAIL midrst_result: got %h expected 0", bus.result); else pass_cnt++;
    #1 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    total_cnt++;
    if (dones !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", dones); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    tick(); tick();
    test_edges();
    test_random();
    tick(); tick();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
